// File: rtl/wb_user_slave_sched.sv
// rtl/wb_user_slave_sched.sv - Wishbone user-area slave scheduler for three internal targets
// Optional WB_USER_SCHED_TIMEOUT_EN adds a watchdog that ends hung forwards with ERR_DATA.
module wb_user_slave_sched #(
  parameter logic [28:0] DBG_TAG        = 29'h601FFFF,
  parameter logic [7:0]  GPIO_PAGE      = 8'h01,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  s_cyc_o,
  input  logic [2:0]  s_ack_i,
  input  logic [95:0] s_dat_i,
  output logic        busy_o,
  output logic        tmo_err_o
);

  typedef enum logic [1:0] {IDLE, FWD, DONE} state_t;

  state_t      state_q;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  s_cyc_q;
  logic        ack_q, busy_q;
  logic [31:0] dat_q;
  logic        sel_ack;
  logic [31:0] sel_dat;

  // Debug window wins over the GPIO page so the last user words always reach the debug regs.
  always_comb begin
    sel_d = 2'd0;
    if (wbs_adr_i[31:3] == DBG_TAG)
      sel_d = 2'd2;
    else if (wbs_adr_i[23:16] == GPIO_PAGE)
      sel_d = 2'd1;
  end

  always_comb begin
    sel_ack = s_ack_i[0];
    sel_dat = s_dat_i[31:0];
    case (sel_q)
      2'd1: begin
        sel_ack = s_ack_i[1];
        sel_dat = s_dat_i[63:32];
      end
      2'd2: begin
        sel_ack = s_ack_i[2];
        sel_dat = s_dat_i[95:64];
      end
      default: ;
    endcase
  end

`ifdef WB_USER_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        tmo_q;
  assign tmo_err_o = tmo_q;
`else
  assign tmo_err_o = 1'b0;
  wire unused_tmo_cfg = ^{ERR_DATA, TIMEOUT_CYCLES};
`endif

  wire unused_in = ^{wbs_adr_i[2:0], wbs_we_i};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      s_cyc_q <= 3'b000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dat_q   <= 32'd0;
`ifdef WB_USER_SCHED_TIMEOUT_EN
      cnt_q   <= 16'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (wbs_cyc_i && wbs_stb_i) begin
            sel_q   <= sel_d;
            s_cyc_q <= 3'b001 << sel_d;
            busy_q  <= 1'b1;
`ifdef WB_USER_SCHED_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
            state_q <= FWD;
          end
        end
        FWD: begin
          // Abort outranks a same-cycle slave ack; the ack is simply dropped.
          if (!wbs_cyc_i) begin
            s_cyc_q <= 3'b000;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sel_ack) begin
            ack_q   <= 1'b1;
            dat_q   <= sel_dat;
            s_cyc_q <= 3'b000;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
`ifdef WB_USER_SCHED_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            ack_q   <= 1'b1;
            dat_q   <= ERR_DATA;
            s_cyc_q <= 3'b000;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
`endif
        end
        DONE: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign s_cyc_o   = s_cyc_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_wb_user_slave_sched.sv
// tb/tb_wb_user_slave_sched.sv - randomized transaction-level bench for wb_user_slave_sched
module tb_wb_user_slave_sched;

`ifdef WB_USER_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 8;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] dat;
  logic [2:0]  s_cyc;
  logic [2:0]  s_ack;
  logic [95:0] s_dat;
  logic        busy, tmo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] last_dat = 32'd0;
  logic        tmo_exp  = 1'b0;

  always #5 clk = ~clk;

  wb_user_slave_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat),
    .s_cyc_o  (s_cyc),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_dat),
    .busy_o   (busy),
    .tmo_err_o(tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_slot(input logic [31:0] a);
    if ((a >> 3) == 32'h0601_FFFF) return 2;
    if (((a >> 16) & 32'hFF) == 32'h1) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom % 4)
      0: return 32'h300F_FFF8 | ($urandom % 8);
      1: return ($urandom & 32'hFF00_FFFF) | 32'h0001_0000;
      2: return 32'h3000_0000 | ($urandom & 32'hFFFF);
      default: return $urandom;
    endcase
  endfunction

  // delay = FWD cycles before the selected slave acks; abort drops cyc in that cycle instead.
  task automatic run_txn(input logic [31:0] a, input logic w, input int delay,
                         input bit abort, input bit noise);
    int          slot;
    logic [2:0]  oh;
    bit          timeout;
    int          stop;
    logic [31:0] word;
    slot    = ref_slot(a);
    oh      = 3'(1 << slot);
    timeout = TMO_EN && !abort && (delay > TMO - 1);
    stop    = timeout ? TMO - 1 : delay;
    word    = 32'd0;

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a;
    s_ack = noise ? 3'($urandom % 8) & ~oh : 3'b000;
    @(posedge clk); #1;
    check("fwd_scyc", 32'(s_cyc), 32'(oh));
    check("fwd_busy", 32'(busy), 32'd1);
    check("fwd_noack", 32'(ack), 32'd0);

    for (int i = 0; i <= stop; i++) begin
      @(negedge clk);
      s_dat = {$urandom, $urandom, $urandom};
      s_ack = noise ? 3'($urandom % 8) & ~oh : 3'b000;
      if (i == delay && !timeout) s_ack = s_ack | oh;
      if (abort && i == delay) begin
        cyc = 1'b0; stb = 1'b0;
      end
      word = s_dat[slot*32 +: 32];
      @(posedge clk); #1;
      if (i < stop) begin
        check("wait_scyc", 32'(s_cyc), 32'(oh));
        check("wait_noack", 32'(ack), 32'd0);
      end
    end

    if (abort) begin
      check("abort_noack", 32'(ack), 32'd0);
      check("abort_scyc", 32'(s_cyc), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_dat_hold", dat, last_dat);
    end else begin
      last_dat = timeout ? 32'hDEAD_BEEF : word;
      if (timeout) tmo_exp = 1'b1;
      check("done_ack", 32'(ack), 32'd1);
      check("done_dat", dat, last_dat);
      check("done_scyc", 32'(s_cyc), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
    end
    check("tmo_flag", 32'(tmo), 32'(tmo_exp));

    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    s_ack = noise ? 3'($urandom % 8) : 3'b000;
    @(posedge clk); #1;
    check("ack_pulse_end", 32'(ack), 32'd0);
    check("idle_scyc", 32'(s_cyc), 32'd0);
    check("dat_hold", dat, last_dat);
    @(negedge clk);
    s_ack = 3'b000;
  endtask

  task automatic reset_mid_fwd();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000; s_ack = 3'b000;
    @(posedge clk); #1;
    check("rst_pre_scyc", 32'(s_cyc), 32'd1);
    @(negedge clk);
    rst = 1'b1; s_ack = 3'b111; s_dat = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    last_dat = 32'd0;
    tmo_exp  = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_scyc", 32'(s_cyc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ack", 32'(ack), 32'd0);
    check("post_rst_scyc", 32'(s_cyc), 32'd0);
    @(negedge clk);
    s_ack = 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0;
    s_ack = 3'b000; s_dat = 96'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dat", dat, 32'd0);
    check("reset_scyc", 32'(s_cyc), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tmo", 32'(tmo), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(32'h3000_0000, 1'b0, 1, 1'b0, 1'b0);
    run_txn(32'h300F_FFFC, 1'b1, 0, 1'b0, 1'b0);
    run_txn(32'h3001_0004, 1'b0, 2, 1'b0, 1'b0);
    run_txn(32'h3000_0040, 1'b0, 4, 1'b0, 1'b1);
    run_txn(32'h3000_0010, 1'b0, 1, 1'b1, 1'b0);
    if (TMO_EN) run_txn(32'h3000_0020, 1'b0, TMO + 3, 1'b0, 1'b0);
    if (TMO_EN) run_txn(32'h3001_0000, 1'b0, TMO - 1, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      bit ab;
      int d;
      ab = ($urandom % 6) == 0;
      d  = ab ? int'($urandom % 6) : int'($urandom % 12);
      run_txn(rand_addr(), 1'($urandom), d, ab, 1'($urandom));
    end

    reset_mid_fwd();
    run_txn(32'h300F_FFF8, 1'b0, 2, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
